// File: rtl/trdb_branch_map_multi_if.sv
// Bundle between the retire stage, the branch map and the packet emitter.
// The slave side is the map; the master side drives retire lanes and flush.
interface trdb_branch_map_multi_if #(
  parameter int DEPTH = 31,
  parameter int NRET  = 2,
  parameter int PBC_W = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NRET-1:0]  valid_i;
  logic [NRET-1:0]  branch_taken_i;
  logic [NRET-1:0]  branch_taken_prediction_i;
  logic             flush_i;
  logic [DEPTH-1:0] map_o;
  logic [CNT_W-1:0] branches_o;
  logic [PBC_W-1:0] pbc_o;
  logic             misprediction_o;
  logic             overflow_o;
  logic             is_full_o;
  logic             is_empty_o;

  modport slave (
    input  valid_i, branch_taken_i, branch_taken_prediction_i, flush_i,
    output map_o, branches_o, pbc_o, misprediction_o, overflow_o,
           is_full_o, is_empty_o
  );

  modport master (
    output valid_i, branch_taken_i, branch_taken_prediction_i, flush_i,
    input  map_o, branches_o, pbc_o, misprediction_o, overflow_o,
           is_full_o, is_empty_o
  );
endinterface

// File: rtl/trdb_branch_map_multi.sv
// Branch map for the trace encoder: compacts up to NRET retired branch
// outcomes per cycle into a DEPTH-entry map, with optional prediction stats.
module trdb_branch_map_multi #(
  parameter int DEPTH   = 31,
  parameter int NRET    = 2,
  parameter bit PRED_EN = 1'b1,
  parameter int PBC_W   = 16
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  trdb_branch_map_multi_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_map;
  logic [CNT_W-1:0] r_branches;
  logic             r_overflow;
  logic             r_full;
  logic             r_empty;

  logic [DEPTH-1:0] w_map_nxt;
  logic [CNT_W-1:0] w_branches_nxt;
  logic             w_overflow_nxt;

  // Flush is applied first, so the push base is zero whenever flush_i is high.
  always_comb begin : push_comb
    int v_idx;
    w_map_nxt      = bus.flush_i ? '0 : r_map;
    w_overflow_nxt = bus.flush_i ? 1'b0 : r_overflow;
    v_idx          = bus.flush_i ? 0 : int'(r_branches);
    for (int j = 0; j < NRET; j++) begin
      if (bus.valid_i[j]) begin
        if (v_idx < DEPTH) begin
          for (int b = 0; b < DEPTH; b++) begin
            if (b == v_idx) w_map_nxt[b] = ~bus.branch_taken_i[j];
          end
        end else begin
          w_overflow_nxt = 1'b1;
        end
        v_idx = v_idx + 1;
      end
    end
    if (v_idx > DEPTH) v_idx = DEPTH;
    w_branches_nxt = CNT_W'(v_idx);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_map      <= '0;
      r_branches <= '0;
      r_overflow <= 1'b0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
    end else begin
      r_map      <= w_map_nxt;
      r_branches <= w_branches_nxt;
      r_overflow <= w_overflow_nxt;
      r_full     <= (int'(w_branches_nxt) > (DEPTH - NRET));
      r_empty    <= (w_branches_nxt == '0);
    end
  end

  assign bus.map_o      = r_map;
  assign bus.branches_o = r_branches;
  assign bus.overflow_o = r_overflow;
  assign bus.is_full_o  = r_full;
  assign bus.is_empty_o = r_empty;

  generate
    if (PRED_EN) begin : g_pred
      logic [PBC_W-1:0] r_pbc;
      logic             r_mis;
      logic [PBC_W+2:0] w_pbc_sum;
      logic             w_mis;

      // Counted on every valid lane, including lanes dropped by a full map.
      always_comb begin : pred_comb
        int v_corr;
        v_corr = 0;
        for (int j = 0; j < NRET; j++) begin
          if (bus.valid_i[j] && (bus.branch_taken_i[j] == bus.branch_taken_prediction_i[j]))
            v_corr = v_corr + 1;
        end
        w_mis     = |(bus.valid_i & (bus.branch_taken_i ^ bus.branch_taken_prediction_i));
        w_pbc_sum = (bus.flush_i ? '0 : {3'b000, r_pbc}) + (PBC_W + 3)'(v_corr);
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_pbc <= '0;
          r_mis <= 1'b0;
        end else begin
          r_pbc <= (w_pbc_sum > {3'b000, {PBC_W{1'b1}}}) ? {PBC_W{1'b1}}
                                                         : w_pbc_sum[PBC_W-1:0];
          r_mis <= w_mis;
        end
      end

      assign bus.pbc_o           = r_pbc;
      assign bus.misprediction_o = r_mis;
    end else begin : g_no_pred
      logic w_unused_pred;
      assign w_unused_pred       = ^bus.branch_taken_prediction_i;
      assign bus.pbc_o           = '0;
      assign bus.misprediction_o = 1'b0;
    end
  endgenerate
endmodule
